imem_boot_loader: RTL

Instruction memory plus serial program loader placed directly upstream of the single-cycle RISC-V core. It supplies the instruction word for the core's PC. After reset it holds the core in reset while it fills memory from a byte stream (UART receiver side) framed as header, payload and checksum. On a valid checksum it releases the core.

---
 rtl/imem_boot_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Instruction memory with a serial boot loader: holds the core in reset while a framed
// byte stream fills memory. Optional macro IMEM_NOP_FILL_EN returns NOP for unwritten words.
module imem_boot_loader #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_CNT  = 17'(DEPTH);
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERR} state_t;

  state_t      state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [1:0]  idx_reg, idx_next;
  logic [7:0]  acc_reg, acc_next;
  logic [15:0] words_reg, words_next;
  logic [31:0] timer_reg, timer_next;
  logic [23:0] asm_reg, asm_next;

  logic        accept;
  logic        timed;
  logic        wr_en;
  logic [31:0] wr_word;
  logic [15:0] hdr_count;
  logic [15:0] words_inc;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  logic [31:0] mem [DEPTH];

  assign in_ready     = (state_reg == HDR0) || (state_reg == HDR1) ||
                        (state_reg == DATA) || (state_reg == CSUM);
  assign core_hold    = (state_reg != RUN);
  assign load_done    = (state_reg == RUN);
  assign load_err     = (state_reg == ERR);
  assign words_loaded = words_reg;

  assign accept    = in_valid && in_ready;
  assign timed     = (state_reg == HDR1) || (state_reg == DATA) || (state_reg == CSUM);
  assign hdr_count = {in_data, count_reg[7:0]};
  assign words_inc = words_reg + 16'd1;
  assign wr_word   = {in_data, asm_reg};
  assign wr_addr   = words_reg[AW-1:0];
  assign rd_addr   = PC[AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HDR0;
      count_reg <= '0;
      idx_reg   <= '0;
      acc_reg   <= '0;
      words_reg <= '0;
      timer_reg <= '0;
      asm_reg   <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
      acc_reg   <= acc_next;
      words_reg <= words_next;
      timer_reg <= timer_next;
      asm_reg   <= asm_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    acc_next   = acc_reg;
    words_next = words_reg;
    timer_next = timer_reg;
    asm_next   = asm_reg;
    wr_en      = 1'b0;

    case (state_reg)
      HDR0: begin
        if (accept) begin
          count_next[7:0] = in_data;
          state_next      = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          count_next[15:8] = in_data;
          if ({1'b0, hdr_count} > DEPTH_CNT)
            state_next = ERR;
          else if (hdr_count == 16'd0)
            state_next = CSUM;
          else
            state_next = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          acc_next = acc_reg ^ in_data;
          idx_next = idx_reg + 2'd1;
          case (idx_reg)
            2'd0: asm_next[7:0]   = in_data;
            2'd1: asm_next[15:8]  = in_data;
            2'd2: asm_next[23:16] = in_data;
            default: begin
              // Fourth byte completes the word and is written straight from the bus.
              wr_en      = 1'b1;
              words_next = words_inc;
              if (words_inc == count_reg)
                state_next = CSUM;
            end
          endcase
        end
      end
      CSUM: begin
        if (accept)
          state_next = (in_data == acc_reg) ? RUN : ERR;
      end
      default: ;
    endcase

    if (accept) begin
      timer_next = '0;
    end else if (timed && (TIMEOUT != 0)) begin
      if (timer_reg == TIMER_LAST)
        state_next = ERR;
      timer_next = timer_reg + 32'd1;
    end
  end

  // A write coinciding with rst is dropped along with the byte that caused it.
  always_ff @(posedge clk) begin
    if (wr_en && !rst)
      mem[wr_addr] <= wr_word;
  end

`ifdef IMEM_NOP_FILL_EN
  logic [DEPTH-1:0] written_bits;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_written
      always_ff @(posedge clk) begin
        if (rst)
          written_bits[gi] <= 1'b0;
        else if (wr_en && (wr_addr == AW'(gi)))
          written_bits[gi] <= 1'b1;
      end
    end
  endgenerate

  assign Instr = written_bits[rd_addr] ? mem[rd_addr] : 32'h0000_0013;
`else
  assign Instr = mem[rd_addr];
`endif

  logic unused_pc;
  assign unused_pc = ^{PC[31:AW+2], PC[1:0]};

endmodule
